// File: rtl/cpu_ctrl_pkg.sv
// Shared state codes, opcodes, control/strobe payloads and decode helpers for the CPU control sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned OPW_DEF = 4;
    localparam int unsigned SCW_DEF = 5;
    localparam int unsigned SC_BITS = 5;
    localparam int unsigned WCW     = 4;

    localparam logic [SC_BITS-1:0] S_FETCH1 = 5'b10000;
    localparam logic [SC_BITS-1:0] S_FETCH2 = 5'b10001;
    localparam logic [SC_BITS-1:0] S_FETCH3 = 5'b10010;
    localparam logic [SC_BITS-1:0] S_LD1    = 5'b00010;
    localparam logic [SC_BITS-1:0] S_LD2    = 5'b00011;
    localparam logic [SC_BITS-1:0] S_ST1    = 5'b00100;
    localparam logic [SC_BITS-1:0] S_ST2    = 5'b00101;
    localparam logic [SC_BITS-1:0] S_JMP1   = 5'b00110;
    localparam logic [SC_BITS-1:0] S_HALT   = 5'b00111;

    localparam logic [3:0] OP_LD   = 4'b0001;
    localparam logic [3:0] OP_ST   = 4'b0010;
    localparam logic [3:0] OP_JMP  = 4'b0011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef struct packed {
        logic ar_ld;
        logic pc_ld;
        logic dr_ld;
        logic ir_ld;
        logic ac_ld;
        logic mem_rd;
        logic mem_wr;
    } ctrl_t;

    typedef struct packed {
        logic fetch1;
        logic fetch2;
        logic fetch3;
        logic ld1;
        logic ld2;
        logic st1;
        logic st2;
        logic jmp1;
    } strobe_t;

    // Moore control lines for a state (pc_inc is event-driven and handled separately).
    function automatic ctrl_t ctrl_decode(input logic [SC_BITS-1:0] s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH1: c.ar_ld = 1'b1;
            S_FETCH2: begin c.mem_rd = 1'b1; c.dr_ld = 1'b1; end
            S_FETCH3: begin c.ir_ld = 1'b1;  c.ar_ld = 1'b1; end
            S_LD1:    begin c.mem_rd = 1'b1; c.dr_ld = 1'b1; end
            S_LD2:    c.ac_ld  = 1'b1;
            S_ST1:    c.dr_ld  = 1'b1;
            S_ST2:    c.mem_wr = 1'b1;
            S_JMP1:   c.pc_ld  = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic strobe_t strobe_decode(input logic [SC_BITS-1:0] s);
        strobe_t t;
        t = '0;
        case (s)
            S_FETCH1: t.fetch1 = 1'b1;
            S_FETCH2: t.fetch2 = 1'b1;
            S_FETCH3: t.fetch3 = 1'b1;
            S_LD1:    t.ld1    = 1'b1;
            S_LD2:    t.ld2    = 1'b1;
            S_ST1:    t.st1    = 1'b1;
            S_ST2:    t.st2    = 1'b1;
            S_JMP1:   t.jmp1   = 1'b1;
            default:  t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Memory handshake between the control sequencer (master) and the memory (slave).
interface control_sequencer_if;
    logic mem_rd;
    logic mem_wr;
    logic mem_rdy;

    modport master (output mem_rd, output mem_wr, input mem_rdy);
    modport slave  (input mem_rd, input mem_wr, output mem_rdy);
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter; tmo_c flags the TMO-th consecutive not-ready cycle.
module mem_wait_timer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TMO = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic en,
    output logic tmo_c
);

    logic [WCW-1:0] cnt;

    assign tmo_c = en && (cnt == WCW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (clr || clear || tmo_c) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WCW'(1);
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// CPU control-state sequencer: fetch/execute FSM, control lines, retire counter, mem_rdy timeout.
// Optional HALT_INSN_EN: opcode 1111 enters a terminal HALT state instead of acting as a NOP.
// pc_inc and mem_err are registered events, visible in the cycle after the edge that caused them.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPW  = OPW_DEF,
    parameter int unsigned SCW  = SCW_DEF,
    parameter int unsigned CNTW = 8,
    parameter int unsigned TMO  = 15
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [OPW-1:0]       ir_op,
    control_sequencer_if.master  mem,
    output logic [SCW-1:0]       state_code,
    output logic                 fetch1,
    output logic                 fetch2,
    output logic                 fetch3,
    output logic                 ld1,
    output logic                 ld2,
    output logic                 st1,
    output logic                 st2,
    output logic                 jmp1,
    output logic                 ar_ld,
    output logic                 pc_inc,
    output logic                 pc_ld,
    output logic                 dr_ld,
    output logic                 ir_ld,
    output logic                 ac_ld,
    output logic [CNTW-1:0]      retired,
    output logic                 mem_err
);

    logic [SC_BITS-1:0] state, state_next;
    logic               retire, pc_inc_d, err_d;
    logic               in_wait, tmo_c;
    ctrl_t              ctrl_q;
    strobe_t            stb_q;

    assign in_wait = (state == S_FETCH2) || (state == S_LD1) || (state == S_ST2);

    mem_wait_timer #(.TMO(TMO)) u_timer (
        .clk   (clk),
        .clr   (clr),
        .clear (!in_wait || mem.mem_rdy),
        .en    (in_wait && !mem.mem_rdy),
        .tmo_c (tmo_c)
    );

    // Next-state and event logic
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        pc_inc_d   = 1'b0;
        err_d      = 1'b0;
        case (state)
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: begin
                if (mem.mem_rdy) begin
                    state_next = S_FETCH3;
                    pc_inc_d   = 1'b1;
                end
            end
            S_FETCH3: begin
                if (ir_op == OPW'(OP_LD)) begin
                    state_next = S_LD1;
                end else if (ir_op == OPW'(OP_ST)) begin
                    state_next = S_ST1;
                end else if (ir_op == OPW'(OP_JMP)) begin
                    state_next = S_JMP1;
`ifdef HALT_INSN_EN
                end else if (ir_op == OPW'(OP_HALT)) begin
                    state_next = S_HALT;
                    retire     = 1'b1;
`endif
                end else begin
                    state_next = S_FETCH1;
                    retire     = 1'b1;
                end
            end
            S_LD1: if (mem.mem_rdy) state_next = S_LD2;
            S_LD2: begin
                state_next = S_FETCH1;
                retire     = 1'b1;
            end
            S_ST1: state_next = S_ST2;
            S_ST2: begin
                if (mem.mem_rdy) begin
                    state_next = S_FETCH1;
                    retire     = 1'b1;
                end
            end
            S_JMP1: begin
                state_next = S_FETCH1;
                retire     = 1'b1;
            end
`ifdef HALT_INSN_EN
            S_HALT: state_next = S_HALT;
`endif
            default: state_next = S_FETCH1;
        endcase
        // Timeout abandons the access: back to fetch, nothing retired
        if (tmo_c) begin
            state_next = S_FETCH1;
            err_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= S_FETCH1;
            ctrl_q  <= ctrl_decode(S_FETCH1);
            stb_q   <= strobe_decode(S_FETCH1);
            pc_inc  <= 1'b0;
            mem_err <= 1'b0;
            retired <= '0;
        end else begin
            state   <= state_next;
            ctrl_q  <= ctrl_decode(state_next);
            stb_q   <= strobe_decode(state_next);
            pc_inc  <= pc_inc_d;
            mem_err <= err_d;
            if (retire) begin
                retired <= retired + CNTW'(1);
            end
        end
    end

    assign state_code = SCW'(state);
    assign fetch1     = stb_q.fetch1;
    assign fetch2     = stb_q.fetch2;
    assign fetch3     = stb_q.fetch3;
    assign ld1        = stb_q.ld1;
    assign ld2        = stb_q.ld2;
    assign st1        = stb_q.st1;
    assign st2        = stb_q.st2;
    assign jmp1       = stb_q.jmp1;
    assign ar_ld      = ctrl_q.ar_ld;
    assign pc_ld      = ctrl_q.pc_ld;
    assign dr_ld      = ctrl_q.dr_ld;
    assign ir_ld      = ctrl_q.ir_ld;
    assign ac_ld      = ctrl_q.ac_ld;
    assign mem.mem_rd = ctrl_q.mem_rd;
    assign mem.mem_wr = ctrl_q.mem_wr;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector table, corner sequences and a random run vs a named-state model.
module tb_control_sequencer;

    localparam int unsigned TMO = 15;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] ir_op;
    logic [4:0] state_code;
    logic       fetch1, fetch2, fetch3, ld1, ld2, st1, st2, jmp1;
    logic       ar_ld, pc_inc, pc_ld, dr_ld, ir_ld, ac_ld;
    logic [7:0] retired;
    logic       mem_err;

    control_sequencer_if bus ();

    control_sequencer #(.OPW(4), .SCW(5), .CNTW(8), .TMO(TMO)) dut (
        .clk(clk), .clr(clr), .ir_op(ir_op), .mem(bus),
        .state_code(state_code),
        .fetch1(fetch1), .fetch2(fetch2), .fetch3(fetch3), .ld1(ld1),
        .ld2(ld2), .st1(st1), .st2(st2), .jmp1(jmp1),
        .ar_ld(ar_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .dr_ld(dr_ld),
        .ir_ld(ir_ld), .ac_ld(ac_ld), .retired(retired), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // {code, strobes, ctrl, retired, mem_err}; ctrl = ar_ld,pc_inc,pc_ld,dr_ld,ir_ld,ac_ld,mem_rd,mem_wr
    logic [29:0] obs;
    assign obs = {state_code,
                  {fetch1, fetch2, fetch3, ld1, ld2, st1, st2, jmp1},
                  {ar_ld, pc_inc, pc_ld, dr_ld, ir_ld, ac_ld, bus.mem_rd, bus.mem_wr},
                  retired, mem_err};

    int checks = 0;
    int errors = 0;

    // Reference model: named states, a not-ready run length and an integer retire count
    string m_st   = "F1";
    int    m_wait = 0;
    int    m_ret  = 0;
    bit    m_err  = 1'b0;
    bit    m_pc   = 1'b0;

    function automatic bit is_wait(input string s);
        return (s == "F2") || (s == "LD1") || (s == "ST2");
    endfunction

    task automatic model_step(input bit c, input logic [3:0] op, input bit rdy);
        string nx;
        bit    ret_now;
        m_err   = 1'b0;
        m_pc    = 1'b0;
        ret_now = 1'b0;
        if (c) begin
            m_st = "F1"; m_wait = 0; m_ret = 0;
        end else begin
            nx = m_st;
            case (m_st)
                "F1": nx = "F2";
                "F2": if (rdy) begin nx = "F3"; m_pc = 1'b1; end
                "F3": begin
                    if (op == 4'd1)      nx = "LD1";
                    else if (op == 4'd2) nx = "ST1";
                    else if (op == 4'd3) nx = "JMP1";
`ifdef HALT_INSN_EN
                    else if (op == 4'd15) begin nx = "HALT"; ret_now = 1'b1; end
`endif
                    else begin nx = "F1"; ret_now = 1'b1; end
                end
                "LD1":  if (rdy) nx = "LD2";
                "LD2":  begin nx = "F1"; ret_now = 1'b1; end
                "ST1":  nx = "ST2";
                "ST2":  if (rdy) begin nx = "F1"; ret_now = 1'b1; end
                "JMP1": begin nx = "F1"; ret_now = 1'b1; end
                default: nx = m_st;
            endcase
            if (is_wait(m_st) && !rdy) begin
                m_wait++;
                if (m_wait == TMO) begin nx = "F1"; m_err = 1'b1; end
            end
            if (nx != m_st) m_wait = 0;
            if (ret_now) m_ret = (m_ret + 1) % 256;
            m_st = nx;
        end
    endtask

    function automatic logic [29:0] model_vec();
        logic [4:0] code;
        logic [7:0] stb, ctl;
        case (m_st)
            "F1":   begin code = 5'b10000; stb = 8'h80; ctl = 8'h80; end
            "F2":   begin code = 5'b10001; stb = 8'h40; ctl = 8'h12; end
            "F3":   begin code = 5'b10010; stb = 8'h20; ctl = 8'h88; end
            "LD1":  begin code = 5'b00010; stb = 8'h10; ctl = 8'h12; end
            "LD2":  begin code = 5'b00011; stb = 8'h08; ctl = 8'h04; end
            "ST1":  begin code = 5'b00100; stb = 8'h04; ctl = 8'h10; end
            "ST2":  begin code = 5'b00101; stb = 8'h02; ctl = 8'h01; end
            "JMP1": begin code = 5'b00110; stb = 8'h01; ctl = 8'h20; end
            default: begin code = 5'b00111; stb = 8'h00; ctl = 8'h00; end
        endcase
        ctl[6] = m_pc;
        return {code, stb, ctl, 8'(m_ret), m_err};
    endfunction

    task automatic check(input string name, input logic [29:0] got, input logic [29:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: drive, clock, advance model, compare away from the edge
    task automatic cyc(input bit c, input logic [3:0] op, input bit rdy);
        clr         = c;
        ir_op       = op;
        bus.mem_rdy = rdy;
        @(posedge clk);
        #1;
        model_step(c, op, rdy);
        check($sformatf("model@%s", m_st), obs, model_vec());
    endtask

    typedef struct {
        bit         c;
        logic [3:0] op;
        bit         rdy;
        logic [4:0] code;
        logic [7:0] stb;
        logic [7:0] ctl;
        logic [7:0] ret;
        bit         err;
    } vec_t;

    vec_t tbl[$];
    bit   saw_pc;
    int   r0;

    initial begin
        clr = 1'b1; ir_op = 4'd0; bus.mem_rdy = 1'b0;

        // Reset, then LD / ST-with-waits / JMP / NOP transactions, all with hand-derived outputs
        tbl.push_back('{1'b1, 4'd0, 1'b1, 5'b10000, 8'h80, 8'h80, 8'd0, 1'b0});
        tbl.push_back('{1'b1, 4'd0, 1'b1, 5'b10000, 8'h80, 8'h80, 8'd0, 1'b0});
        tbl.push_back('{1'b0, 4'd1, 1'b1, 5'b10001, 8'h40, 8'h12, 8'd0, 1'b0});
        tbl.push_back('{1'b0, 4'd1, 1'b1, 5'b10010, 8'h20, 8'hC8, 8'd0, 1'b0});
        tbl.push_back('{1'b0, 4'd1, 1'b0, 5'b00010, 8'h10, 8'h12, 8'd0, 1'b0});
        tbl.push_back('{1'b0, 4'd1, 1'b1, 5'b00011, 8'h08, 8'h04, 8'd0, 1'b0});
        tbl.push_back('{1'b0, 4'd1, 1'b1, 5'b10000, 8'h80, 8'h80, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 4'd2, 1'b1, 5'b10001, 8'h40, 8'h12, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 4'd2, 1'b1, 5'b10010, 8'h20, 8'hC8, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 4'd2, 1'b1, 5'b00100, 8'h04, 8'h10, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 4'd2, 1'b0, 5'b00101, 8'h02, 8'h01, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 4'd2, 1'b0, 5'b00101, 8'h02, 8'h01, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 4'd2, 1'b0, 5'b00101, 8'h02, 8'h01, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 4'd2, 1'b0, 5'b00101, 8'h02, 8'h01, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 4'd2, 1'b1, 5'b10000, 8'h80, 8'h80, 8'd2, 1'b0});
        tbl.push_back('{1'b0, 4'd3, 1'b1, 5'b10001, 8'h40, 8'h12, 8'd2, 1'b0});
        tbl.push_back('{1'b0, 4'd3, 1'b1, 5'b10010, 8'h20, 8'hC8, 8'd2, 1'b0});
        tbl.push_back('{1'b0, 4'd3, 1'b1, 5'b00110, 8'h01, 8'h20, 8'd2, 1'b0});
        tbl.push_back('{1'b0, 4'd3, 1'b1, 5'b10000, 8'h80, 8'h80, 8'd3, 1'b0});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 5'b10001, 8'h40, 8'h12, 8'd3, 1'b0});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 5'b10010, 8'h20, 8'hC8, 8'd3, 1'b0});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 5'b10000, 8'h80, 8'h80, 8'd4, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].c, tbl[i].op, tbl[i].rdy);
            check($sformatf("vec%0d", i), obs,
                  {tbl[i].code, tbl[i].stb, tbl[i].ctl, tbl[i].ret, tbl[i].err});
        end

        // Retire counter wraps after 256 NOPs
        cyc(1'b1, 4'd0, 1'b0);
        for (int n = 0; n < 255; n++) begin
            cyc(1'b0, 4'd0, 1'b1); cyc(1'b0, 4'd0, 1'b1); cyc(1'b0, 4'd0, 1'b1);
        end
        check_val("wrap_255", int'(retired), 255);
        cyc(1'b0, 4'd0, 1'b1); cyc(1'b0, 4'd0, 1'b1); cyc(1'b0, 4'd0, 1'b1);
        check_val("wrap_0", int'(retired), 0);

        // FETCH2 timeout: 15 not-ready cycles, then FETCH1 with a one-cycle mem_err
        saw_pc = 1'b0;
        r0 = int'(retired);
        cyc(1'b0, 4'd0, 1'b0);
        for (int k = 1; k < int'(TMO); k++) begin
            cyc(1'b0, 4'd0, 1'b0);
            saw_pc |= pc_inc;
        end
        check_val("tmo_still_f2", int'(state_code), 5'b10001);
        check_val("tmo_no_err_yet", int'(mem_err), 0);
        cyc(1'b0, 4'd0, 1'b0);
        saw_pc |= pc_inc;
        check_val("tmo_state", int'(state_code), 5'b10000);
        check_val("tmo_err", int'(mem_err), 1);
        check_val("tmo_no_retire", int'(retired), r0);
        check_val("tmo_no_pcinc", int'(saw_pc), 0);
        cyc(1'b0, 4'd0, 1'b1);
        check_val("tmo_err_pulse", int'(mem_err), 0);

        // clr mid-wait with mem_rdy high: clr wins
        cyc(1'b0, 4'd2, 1'b0);
        cyc(1'b0, 4'd2, 1'b1); cyc(1'b0, 4'd2, 1'b1); cyc(1'b0, 4'd2, 1'b1);
        cyc(1'b0, 4'd2, 1'b0); cyc(1'b0, 4'd2, 1'b0);
        cyc(1'b1, 4'd2, 1'b1);
        check_val("clr_wait_state", int'(state_code), 5'b10000);
        check_val("clr_wait_ret", int'(retired), 0);

        // Opcode 1111
        cyc(1'b0, 4'd15, 1'b1); cyc(1'b0, 4'd15, 1'b1); cyc(1'b0, 4'd15, 1'b1);
        check_val("op15_retire", int'(retired), 1);
`ifdef HALT_INSN_EN
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            check($sformatf("halt%0d", k), obs, {5'b00111, 8'h00, 8'h00, 8'd1, 1'b0});
        end
        cyc(1'b1, 4'd0, 1'b0);
        check_val("halt_clr", int'(state_code), 5'b10000);
`else
        check_val("op15_nop", int'(state_code), 5'b10000);
`endif

        // Random run with occasional long stalls and rare clr
        begin
            int stall = 0;
            bit rdy;
            for (int n = 0; n < 3000; n++) begin
                if (stall > 0) begin
                    stall--;
                    rdy = 1'b0;
                end else begin
                    if ($urandom_range(0, 49) == 0) stall = $urandom_range(10, 20);
                    rdy = ($urandom_range(0, 9) < 7);
                end
                cyc(($urandom_range(0, 149) == 0), 4'($urandom_range(0, 15)), rdy);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
